// File: rtl/nvdla_dbb_rd_engine.sv
// DBB read engine: queues burst read requests, issues single-beat memory reads under credit, returns beats in order.
// Optional NVDLA_DBB_RD_PERF_EN adds saturating handshake/stall counters (perf_beats_o, perf_stall_o).

// Generic synchronous FIFO used for request queue, beat tags and response data.
// Latency: a push is visible on rd_vld the following cycle; no fall-through.
// Backpressure: push accepted when not full or when a pop happens in the same cycle.
module nvdla_dbb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     clear_i,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     full,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign rd_vld  = (cnt != '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = rd_vld & rd_rdy;
  assign do_push = wr_vld & (!full | do_pop);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push & do_pop) cnt <= cnt - 1'b1;
    end
  end
endmodule

// Splits queued bursts into memory beats and returns tagged beats to the core in order.
// Latency: request accept -> first rdat_valid_o in 3 cycles with a zero-wait memory.
// Backpressure: req_ready_o = queue not full; issue is throttled by free response credit.
module nvdla_dbb_rd_engine #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int MAX_OUTST  = 4,
  parameter int RESP_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_add_o,
  input  logic                  mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_r_data_i,
  output logic                  rdat_valid_o,
  input  logic                  rdat_ready_i,
  output logic [DATA_WIDTH-1:0] rdat_data_o,
  output logic                  rdat_last_o,
  output logic [ID_WIDTH-1:0]   rdat_id_o,
`ifdef NVDLA_DBB_RD_PERF_EN
  output logic                  busy_o,
  output logic [31:0]           perf_beats_o,
  output logic [31:0]           perf_stall_o
`else
  output logic                  busy_o
`endif
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int CW         = $clog2(RESP_DEPTH) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                last;
  } tag_t;

  typedef struct packed {
    tag_t                  tag;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  req_t  head, req_in;
  tag_t  tag_in, tag_head;
  resp_t resp_in, resp_head;

  logic                       q_vld, q_full, q_pop;
  logic [$clog2(MAX_OUTST):0] q_cnt;
  logic                       tag_vld, tag_full;
  logic [CW-1:0]              inflight;
  logic                       resp_full;
  logic [CW-1:0]              resp_cnt;

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q, cur_addr;
  logic [LEN_WIDTH-1:0]  cnt_q, cur_cnt;
  logic [ID_WIDTH-1:0]   id_q, cur_id;
  logic                  from_head, credit_ok, grant, last_beat, r_acc;
  logic                  unused_ok;

  assign req_in      = '{addr: req_addr_i, len: req_len_i, id: req_id_i};
  assign req_ready_o = !q_full;

  nvdla_dbb_fifo #(.WIDTH($bits(req_t)), .DEPTH(MAX_OUTST)) u_req_q (
    .clk_i(clk_i), .clear_i(clear_i),
    .wr_vld(req_valid_i & req_ready_o), .wr_dat(req_in), .full(q_full),
    .rd_vld(q_vld), .rd_rdy(q_pop), .rd_dat(head), .cnt(q_cnt)
  );

  // While idle the queue head is issued directly, saving a load cycle on the first beat.
  assign from_head = (state_q == IDLE) & q_vld;
  assign cur_addr  = from_head ? head.addr : addr_q;
  assign cur_cnt   = from_head ? head.len  : cnt_q;
  assign cur_id    = from_head ? head.id   : id_q;
  assign last_beat = (cur_cnt == '0);

  assign credit_ok = ({1'b0, inflight} + {1'b0, resp_cnt}) < (CW+1)'(RESP_DEPTH);
  assign mem_req_o = ((state_q == ISSUE) | q_vld) & enable_i & credit_ok;
  assign mem_add_o = cur_addr;
  assign grant     = mem_req_o & mem_gnt_i;
  assign q_pop     = q_vld & enable_i & ((state_q == IDLE) | (grant & last_beat));

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      if (grant) begin
        addr_q  <= cur_addr + ADDR_WIDTH'(BEAT_BYTES);
        cnt_q   <= cur_cnt - 1'b1;
        id_q    <= cur_id;
        state_q <= last_beat ? IDLE : ISSUE;
      end else if (from_head & enable_i) begin
        addr_q  <= cur_addr;
        cnt_q   <= cur_cnt;
        id_q    <= cur_id;
        state_q <= ISSUE;
      end
      // Back-to-back: next burst is loaded in the cycle the previous last beat is granted.
      if ((state_q == ISSUE) & grant & last_beat & q_vld & enable_i) begin
        addr_q  <= head.addr;
        cnt_q   <= head.len;
        id_q    <= head.id;
        state_q <= ISSUE;
      end
    end
  end

  // Tag FIFO occupancy is the in-flight beat count; r_valid with nothing in flight is dropped.
  assign tag_in = '{id: cur_id, last: last_beat};
  assign r_acc  = mem_r_valid_i & tag_vld;

  nvdla_dbb_fifo #(.WIDTH($bits(tag_t)), .DEPTH(RESP_DEPTH)) u_tag_q (
    .clk_i(clk_i), .clear_i(clear_i),
    .wr_vld(grant), .wr_dat(tag_in), .full(tag_full),
    .rd_vld(tag_vld), .rd_rdy(r_acc), .rd_dat(tag_head), .cnt(inflight)
  );

  assign resp_in = '{tag: tag_head, data: mem_r_data_i};

  nvdla_dbb_fifo #(.WIDTH($bits(resp_t)), .DEPTH(RESP_DEPTH)) u_resp_q (
    .clk_i(clk_i), .clear_i(clear_i),
    .wr_vld(r_acc), .wr_dat(resp_in), .full(resp_full),
    .rd_vld(rdat_valid_o), .rd_rdy(rdat_ready_i), .rd_dat(resp_head), .cnt(resp_cnt)
  );

  assign rdat_data_o = rdat_valid_o ? resp_head.data     : '0;
  assign rdat_id_o   = rdat_valid_o ? resp_head.tag.id   : '0;
  assign rdat_last_o = rdat_valid_o ? resp_head.tag.last : 1'b0;

  assign busy_o    = q_vld | (state_q == ISSUE) | tag_vld | rdat_valid_o;
  assign unused_ok = ^{tag_full, resp_full, q_cnt};

`ifdef NVDLA_DBB_RD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      perf_beats_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (rdat_valid_o & rdat_ready_i & (perf_beats_o != '1))  perf_beats_o <= perf_beats_o + 1'b1;
      if (rdat_valid_o & !rdat_ready_i & (perf_stall_o != '1)) perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif
endmodule
